sr04_echo_emulator: RTL

//   Synthesizable model of the HC-SR04 sensor side: receives trig from SR04_Controller and answers with an

---
 rtl/sr04_pkg.sv | 8 +
 rtl/sr04_us_tick.sv | 17 +
 rtl/sr04_echo_emulator.sv | 86 ++++++++
 3 files changed

// File: rtl/sr04_pkg.sv
// sr04_pkg: shared HC-SR04 state encoding and distance/echo constants.
package sr04_pkg;
    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} sr04_state_e;
    localparam int SR04_US_PER_CM  = 58;
    localparam int SR04_MIN_CM     = 2;
    localparam int SR04_MAX_CM     = 400;
    localparam int SR04_TIMEOUT_US = 38000;
endpackage

// File: rtl/sr04_us_tick.sv
// sr04_us_tick: microsecond prescaler with synchronous clear and one-cycle tick.
module sr04_us_tick #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_PER_US);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLK_PER_US - 1);
    always_ff @(posedge clk) begin
        if (rst || clr || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sr04_echo_emulator.sv
// sr04_echo_emulator: sensor-side HC-SR04 model answering trig with a distance-encoded echo pulse.
module sr04_echo_emulator
    import sr04_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = SR04_US_PER_CM,
    parameter int MIN_CM      = SR04_MIN_CM,
    parameter int MAX_CM      = SR04_MAX_CM,
    parameter int TIMEOUT_US  = SR04_TIMEOUT_US,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       obstacle,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);
    localparam int          CLK_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam logic [15:0] MIN_TRIG   = 16'(MIN_TRIG_US);
    localparam logic [15:0] BURST_END  = 16'(BURST_US - 1);
    localparam logic [15:0] HOLD_END   = 16'(HOLDOFF_US - 1);
    localparam logic [8:0]  MIN_D      = 9'(MIN_CM);
    localparam logic [8:0]  MAX_D      = 9'(MAX_CM);

    sr04_state_e state, state_nx;
    logic        trig_m, trig_s, tick, clr, err_nx;
    logic [15:0] us_cnt, width_us, width_nx;
    logic [8:0]  d_cl;
    logic [16:0] prod;

    sr04_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign d_cl     = distance_cm < MIN_D ? MIN_D : distance_cm;
    assign prod     = 17'(d_cl) * 17'(US_PER_CM);
    assign width_nx = (!obstacle || distance_cm > MAX_D) ? 16'(TIMEOUT_US) : prod[15:0];
    assign clr      = state_nx != state;

    // Entering TRIG_HI one stage early keeps the state aligned with trig_s high time.
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE:    if (trig_m && !trig_s) state_nx = TRIG_HI;
            TRIG_HI: if (!trig_s) begin
                state_nx = us_cnt >= MIN_TRIG ? BURST : IDLE;
                err_nx   = us_cnt < MIN_TRIG;
            end
            BURST:   if (tick && us_cnt == BURST_END) state_nx = ECHO;
            ECHO:    if (tick && us_cnt == width_us - 16'd1) state_nx = HOLDOFF;
            HOLDOFF: if (tick && us_cnt == HOLD_END) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m   <= 1'b0;
            trig_s   <= 1'b0;
            state    <= IDLE;
            us_cnt   <= '0;
            width_us <= '0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            trig_m   <= trig;
            trig_s   <= trig_m;
            state    <= state_nx;
            us_cnt   <= clr ? '0 : (tick && us_cnt != 16'hFFFF) ? us_cnt + 16'd1 : us_cnt;
            if (state == TRIG_HI && state_nx == BURST) width_us <= width_nx;
            echo     <= state_nx == ECHO;
            busy     <= state_nx != IDLE;
            trig_err <= err_nx;
        end
    end
endmodule
